// File: rtl/alu_op_sequencer.sv
// Purpose: issues one command at a time to an external combinational ALU, holds its
//          inputs for a programmable settle time, then captures result and flags.
// Latency: accept edge k -> capture at edge k+SETTLE_CYC+1; o_VALID is up for the
//          cycles after that edge, so a sample taken at edge k+SETTLE_CYC+2 sees it.
// Backpressure: o_VALID/result held in DONE until i_READY; no new command accepted
//          until the result is consumed (issue interval >= SETTLE_CYC+3).
// Ports:
//   i_CLK, i_RST                     clock, synchronous active-high reset
//   i_A, i_B, i_sel, i_VALID/o_READY command channel
//   o_alu_a/b/sel, i_alu_y/overflow/err  external ALU drive and response
//   o_Y, o_overflow, o_err, o_neg, o_pos, o_VALID/i_READY  result channel
//   o_busy, o_err_cnt                status: not idle, saturating ALU error count
module alu_op_sequencer #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [1:0]       i_sel,
  input  logic             i_VALID,
  output logic             o_READY,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_sel,
  input  logic [WIDTH-1:0] i_alu_y,
  input  logic             i_alu_overflow,
  input  logic             i_alu_err,
  output logic [WIDTH-1:0] o_Y,
  output logic             o_overflow,
  output logic             o_err,
  output logic             o_neg,
  output logic             o_pos,
  output logic             o_VALID,
  input  logic             i_READY,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] ERR_MAX   = '1;
  localparam logic [CNT_W-1:0] ERR_ONE   = CNT_W'(1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       capture;

  always_comb begin
    state_nxt = state;
    o_READY   = 1'b0;
    o_VALID   = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        o_READY = 1'b1;
        if (i_VALID) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_VALID = 1'b1;
        if (i_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_sel  <= 2'b00;
      o_Y        <= '0;
      o_overflow <= 1'b0;
      o_err      <= 1'b0;
      o_neg      <= 1'b0;
      o_pos      <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        o_alu_a    <= i_A;
        o_alu_b    <= i_B;
        o_alu_sel  <= i_sel;
        settle_cnt <= SETTLE_LD;
      end else if (state == SETTLE && !capture) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (capture) begin
        o_Y        <= i_alu_y;
        o_overflow <= i_alu_overflow;
        o_err      <= i_alu_err;
        // A flagged ALU error makes the sign of the result meaningless.
        o_neg      <= i_alu_y[WIDTH-1] & ~i_alu_err;
        o_pos      <= ~i_alu_y[WIDTH-1] & (i_alu_y != '0) & ~i_alu_err;
        if (i_alu_err && o_err_cnt != ERR_MAX) o_err_cnt <= o_err_cnt + ERR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a = '0, b = '0, ay = '0;
  logic [1:0] sel = '0;
  logic       vld = 1'b0, rdy = 1'b0, aovf = 1'b0, aerr = 1'b0;

  logic       rdy_o, vld_o, ovf_o, err_o, neg_o, pos_o, busy_o;
  logic [3:0] alu_a, alu_b, y_o;
  logic [1:0] alu_sel, cnt_o;

  logic       rdy0, vld0, ovf0, err0, neg0, pos0, busy0;
  logic [3:0] alu_a0, alu_b0, y0, cnt0;
  logic [1:0] alu_sel0;

  int checks = 0;
  int errors = 0;
  logic got;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYC(1), .CNT_W(2)) u_dut (
    .i_CLK(clk), .i_RST(rst), .i_A(a), .i_B(b), .i_sel(sel), .i_VALID(vld),
    .o_READY(rdy_o), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel),
    .i_alu_y(ay), .i_alu_overflow(aovf), .i_alu_err(aerr),
    .o_Y(y_o), .o_overflow(ovf_o), .o_err(err_o), .o_neg(neg_o), .o_pos(pos_o),
    .o_VALID(vld_o), .i_READY(rdy), .o_busy(busy_o), .o_err_cnt(cnt_o)
  );

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYC(0), .CNT_W(4)) u_dut0 (
    .i_CLK(clk), .i_RST(rst), .i_A(a), .i_B(b), .i_sel(sel), .i_VALID(vld),
    .o_READY(rdy0), .o_alu_a(alu_a0), .o_alu_b(alu_b0), .o_alu_sel(alu_sel0),
    .i_alu_y(ay), .i_alu_overflow(aovf), .i_alu_err(aerr),
    .o_Y(y0), .o_overflow(ovf0), .o_err(err0), .o_neg(neg0), .o_pos(pos0),
    .o_VALID(vld0), .i_READY(rdy), .o_busy(busy0), .o_err_cnt(cnt0)
  );

  // Advance one rising edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one command into the main DUT and wait (bounded) for its result.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] ts,
                        input logic [3:0] ty, input logic tovf, input logic terr);
    for (int i = 0; i < 10 && !rdy_o; i++) step();
    a = ta; b = tb; sel = ts; ay = ty; aovf = tovf; aerr = terr; vld = 1'b1;
    step();
    vld = 1'b0;
    for (int i = 0; i < 10 && !vld_o; i++) step();
    got = vld_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rdy_o); end
    checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", vld_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if ({y_o, alu_a, alu_b, alu_sel} !== 14'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {y_o, alu_a, alu_b, alu_sel}); end
    checks++; if ({ovf_o, err_o, neg_o, pos_o, cnt_o} !== 6'h0) begin errors++; $display("FAIL reset_flags got=%h exp=0", {ovf_o, err_o, neg_o, pos_o, cnt_o}); end
  endtask

  task automatic test_sub_latency();
    rdy = 1'b1; a = 4'd5; b = 4'd3; sel = 2'b00; ay = 4'd2; aovf = 1'b0; aerr = 1'b0; vld = 1'b1;
    step(); vld = 1'b0;  // accept edge
    checks++; if ({alu_a, alu_b, alu_sel} !== {4'd5, 4'd3, 2'b00}) begin errors++; $display("FAIL sub_alu_in got=%h exp=%h", {alu_a, alu_b, alu_sel}, {4'd5, 4'd3, 2'b00}); end
    checks++; if ({rdy_o, busy_o, vld_o} !== 3'b010) begin errors++; $display("FAIL sub_settle_ctl got=%b exp=010", {rdy_o, busy_o, vld_o}); end
    step();
    checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL sub_early_valid got=%b exp=0", vld_o); end
    step();  // capture edge
    checks++; if (vld_o !== 1'b1) begin errors++; $display("FAIL sub_valid got=%b exp=1", vld_o); end
    checks++; if ({y_o, pos_o, neg_o, err_o, ovf_o} !== {4'd2, 4'b1000}) begin errors++; $display("FAIL sub_result got=%h exp=%h", {y_o, pos_o, neg_o, err_o, ovf_o}, {4'd2, 4'b1000}); end
    step();
    checks++; if ({vld_o, rdy_o, busy_o, y_o} !== {3'b010, 4'd2}) begin errors++; $display("FAIL sub_release got=%h exp=%h", {vld_o, rdy_o, busy_o, y_o}, {3'b010, 4'd2}); end
  endtask

  task automatic test_flags();
    run_op(4'd8, 4'd0, 2'b11, 4'hE, 1'b0, 1'b0);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL onehot_timeout got=%b exp=1", got); end
    checks++; if ({y_o, neg_o, pos_o, alu_sel} !== {4'hE, 2'b10, 2'b11}) begin errors++; $display("FAIL onehot_neg got=%h exp=%h", {y_o, neg_o, pos_o, alu_sel}, {4'hE, 2'b10, 2'b11}); end
    run_op(4'd1, 4'd0, 2'b11, 4'h0, 1'b0, 1'b0);
    checks++; if ({got, y_o, neg_o, pos_o} !== {1'b1, 4'h0, 2'b00}) begin errors++; $display("FAIL zero_flags got=%h exp=%h", {got, y_o, neg_o, pos_o}, {1'b1, 4'h0, 2'b00}); end
    run_op(4'd7, 4'hF, 2'b00, 4'h8, 1'b1, 1'b0);
    checks++; if ({got, y_o, ovf_o, neg_o, pos_o} !== {1'b1, 4'h8, 3'b110}) begin errors++; $display("FAIL ovf_flags got=%h exp=%h", {got, y_o, ovf_o, neg_o, pos_o}, {1'b1, 4'h8, 3'b110}); end
    run_op(4'h9, 4'h3, 2'b10, 4'h3, 1'b0, 1'b0);
    checks++; if ({got, y_o, ovf_o, neg_o, pos_o} !== {1'b1, 4'h3, 3'b001}) begin errors++; $display("FAIL pos_flags got=%h exp=%h", {got, y_o, ovf_o, neg_o, pos_o}, {1'b1, 4'h3, 3'b001}); end
    step();
  endtask

  task automatic test_backpressure();
    rdy = 1'b0;
    run_op(4'd1, 4'd2, 2'b01, 4'hD, 1'b0, 1'b0);
    checks++; if ({got, y_o, neg_o} !== {1'b1, 4'hD, 1'b1}) begin errors++; $display("FAIL bp_first got=%h exp=%h", {got, y_o, neg_o}, {1'b1, 4'hD, 1'b1}); end
    a = 4'd9; b = 4'd6; sel = 2'b10; ay = 4'h3; vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({vld_o, rdy_o, y_o, neg_o, pos_o, alu_a, alu_b, alu_sel} !== {2'b10, 4'hD, 2'b10, 4'd1, 4'd2, 2'b01})
        begin errors++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, {vld_o, rdy_o, y_o, neg_o, pos_o, alu_a, alu_b, alu_sel}, {2'b10, 4'hD, 2'b10, 4'd1, 4'd2, 2'b01}); end
    end
    rdy = 1'b1; step();
    checks++; if ({vld_o, rdy_o, busy_o, alu_a} !== {3'b010, 4'd1}) begin errors++; $display("FAIL bp_idle got=%h exp=%h", {vld_o, rdy_o, busy_o, alu_a}, {3'b010, 4'd1}); end
    step(); vld = 1'b0;
    checks++; if ({busy_o, alu_a, alu_b, alu_sel} !== {1'b1, 4'd9, 4'd6, 2'b10}) begin errors++; $display("FAIL bp_accept2 got=%h exp=%h", {busy_o, alu_a, alu_b, alu_sel}, {1'b1, 4'd9, 4'd6, 2'b10}); end
    for (int i = 0; i < 10 && !vld_o; i++) step();
    checks++; if ({vld_o, y_o, pos_o} !== {1'b1, 4'h3, 1'b1}) begin errors++; $display("FAIL bp_result2 got=%h exp=%h", {vld_o, y_o, pos_o}, {1'b1, 4'h3, 1'b1}); end
    step();
  endtask

  task automatic test_err_saturate();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      run_op(4'd3, 4'd4, 2'b00, 4'hF, 1'b0, 1'b1);
      checks++; if ({got, err_o, neg_o, pos_o, cnt_o} !== {4'b1100, exp_cnt[i]})
        begin errors++; $display("FAIL err_sat op=%0d got=%h exp=%h", i, {got, err_o, neg_o, pos_o, cnt_o}, {4'b1100, exp_cnt[i]}); end
    end
    aerr = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    a = 4'd7; b = 4'd7; sel = 2'b01; ay = 4'h8; vld = 1'b1;
    step(); vld = 1'b0;
    step();
    checks++; if ({busy_o, vld_o} !== 2'b10) begin errors++; $display("FAIL mid_presettle got=%b exp=10", {busy_o, vld_o}); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if ({rdy_o, busy_o, vld_o} !== 3'b100) begin errors++; $display("FAIL mid_ctl got=%b exp=100", {rdy_o, busy_o, vld_o}); end
    checks++; if ({y_o, alu_a, alu_b, alu_sel, err_o, neg_o, pos_o, ovf_o, cnt_o} !== 20'h0)
      begin errors++; $display("FAIL mid_zero got=%h exp=0", {y_o, alu_a, alu_b, alu_sel, err_o, neg_o, pos_o, ovf_o, cnt_o}); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL mid_no_valid cyc=%0d got=%b exp=0", i, vld_o); end
    end
    run_op(4'd6, 4'd2, 2'b00, 4'd4, 1'b0, 1'b0);
    checks++; if ({got, y_o, pos_o, cnt_o} !== {1'b1, 4'd4, 1'b1, 2'd0}) begin errors++; $display("FAIL mid_next_op got=%h exp=%h", {got, y_o, pos_o, cnt_o}, {1'b1, 4'd4, 1'b1, 2'd0}); end
    step();
  endtask

  task automatic test_back_to_back();
    int last;
    int n_acc;
    rst = 1'b1; step(); rst = 1'b0;
    rdy = 1'b1; a = 4'd2; b = 4'd1; sel = 2'b00; ay = 4'd1; aerr = 1'b0; aovf = 1'b0; vld = 1'b1;
    step();  // accept edge on the SETTLE_CYC=0 instance
    checks++; if ({busy0, vld0} !== 2'b10) begin errors++; $display("FAIL s0_settle got=%b exp=10", {busy0, vld0}); end
    step();
    checks++; if ({vld0, y0, pos0} !== {1'b1, 4'd1, 1'b1}) begin errors++; $display("FAIL s0_valid got=%h exp=%h", {vld0, y0, pos0}, {1'b1, 4'd1, 1'b1}); end
    last = -1; n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (rdy0) begin
        if (last >= 0) begin
          checks++; if (c - last !== 3) begin errors++; $display("FAIL b2b_spacing got=%0d exp=3", c - last); end
        end
        last = c; n_acc++;
      end
      step();
    end
    vld = 1'b0;
    checks++; if (n_acc !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", n_acc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sub_latency();
    test_flags();
    test_backpressure();
    test_err_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequences single operations through the 4-function combinational ALU (subtract, NAND, starting-ones, one-hot-to-U2 decode). Accepts an operation command over a valid/ready handshake and holds the operands and select stable on the ALU inputs. Waits a programmable settle time, then captures the result and flags. Presents the captured result downstream over a second valid/ready handshake and keeps a saturating error counter. Sits between the command source and the ALU; the ALU itself is external and is driven from this block's o_alu_* ports.

Parameters:
WIDTH, 4, operand/result width in bits (min 2)
SETTLE_CYC, 1, extra cycles operands are held before capture (0..15)
CNT_W, 4, width of the error counter

Ports:
i_CLK  in  1  clock, rising edge
i_RST  in  1  reset, synchronous, active-high
i_A  in  WIDTH  operand A
i_B  in  WIDTH  operand B
i_sel  in  2  op select: 00 sub, 01 nand, 10 starting_ones, 11 onehot-to-U2
i_VALID  in  1  upstream command valid
o_READY  out  1  command accepted when i_VALID & o_READY at a rising edge
o_alu_a  out  WIDTH  registered operand A to ALU
o_alu_b  out  WIDTH  registered operand B to ALU
o_alu_sel  out  2  registered select to ALU
i_alu_y  in  WIDTH  ALU result
i_alu_overflow  in  1  ALU overflow flag
i_alu_err  in  1  ALU error flag
o_Y  out  WIDTH  captured result
o_overflow  out  1  captured overflow
o_err  out  1  captured error
o_neg  out  1  result negative (two's complement)
o_pos  out  1  result strictly positive
o_VALID  out  1  result valid to downstream
i_READY  in  1  downstream ready; result consumed when o_VALID & i_READY
o_busy  out  1  high in any state other than IDLE
o_err_cnt  out  CNT_W  saturating count of captures with err=1

Behaviour:
- Reset, when i_RST=1 at an edge: state=IDLE; o_alu_a/b/sel=0; o_Y=0; o_overflow=o_err=o_neg=o_pos=0; o_VALID=0; o_err_cnt=0; settle counter=0. Reset overrides all other events.
- Reset mid-operation: the in-flight op is dropped with no o_VALID pulse. o_READY is high in the cycle after reset deasserts.
- FSM states: IDLE, SETTLE, DONE.
- IDLE: o_READY=1, o_VALID=0.
  - On i_VALID=1, latch i_A, i_B, i_sel into o_alu_a/b/sel, load counter=SETTLE_CYC, go to SETTLE.
  - With i_VALID=0, stay in IDLE; o_alu_* hold their last values.
- SETTLE: o_READY=0, o_VALID=0.
  - If counter==0: capture i_alu_y, i_alu_overflow, i_alu_err into o_Y/o_overflow/o_err; compute flags; go to DONE.
  - Otherwise decrement the counter.
  - SETTLE lasts exactly SETTLE_CYC+1 cycles.
- DONE: o_VALID=1, o_READY=0; all result outputs and o_alu_* are held stable.
  - On i_READY=1, go to IDLE; o_VALID drops the next cycle.
  - i_VALID is ignored in DONE (no new command accepted).
- Latency: accept at edge k -> o_VALID high from edge k+SETTLE_CYC+2.
  - With i_READY tied high, minimum issue interval is SETTLE_CYC+3 cycles.
- Flags, computed at capture from the captured value:
  - o_neg = y[WIDTH-1].
  - o_pos = ~y[WIDTH-1] & (y!=0).
  - If i_alu_err=1, o_neg=o_pos=0.
  - y=0 gives neg=pos=0.
  - Flags are evaluated for every sel value.
- Error counter: increments by 1 at each capture with i_alu_err=1. It saturates at 2^CNT_W-1 (no wrap) and is cleared only by reset.
- o_busy = (state != IDLE).

Test Plan:
- WIDTH=4, SETTLE_CYC=1, i_READY=1: send A=5, B=3, sel=00 with ALU model y=2 -> o_alu_a=5 and o_alu_sel=00 one cycle after accept; o_VALID high 3 edges after accept; o_Y=2, o_pos=1, o_neg=0.
- sel=11 with model y=4'hE, err=0 -> o_Y=E, o_neg=1, o_pos=0. Then y=0 -> o_neg=o_pos=0.
- Backpressure: hold i_READY=0 for 5 cycles in DONE while i_VALID=1 with new operands -> o_Y, flags and o_alu_* unchanged; o_READY=0; no second accept. Raise i_READY -> IDLE next cycle, then the new command is accepted.
- CNT_W=2: run 5 ops with model err=1, y=4'hF -> o_err=1, o_neg=o_pos=0 each time; o_err_cnt goes 1,2,3,3,3.
- Assert i_RST for 1 cycle during SETTLE -> no o_VALID; all outputs 0; o_READY=1 next cycle; the next op completes normally.
- SETTLE_CYC=0 -> o_VALID high 2 edges after accept. Back-to-back commands with i_READY=1 -> accepts spaced 3 cycles apart.
